// File: rtl/fractal_stream_receiver_if.sv
// Stream bundle for fractal_stream_receiver: unthrottled pixel input plus AXI4-Stream RGB output.
// "slave" is the receiver's view; "master" is the view of the environment driving it.
interface fractal_stream_receiver_if;
  logic [7:0]  s_data;
  logic        s_frame_start;
  logic        s_line_end;
  logic        s_valid;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;

  modport master (
    output s_data, s_frame_start, s_line_end, s_valid, m_axis_tready,
    input  m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid
  );

  modport slave (
    input  s_data, s_frame_start, s_line_end, s_valid, m_axis_tready,
    output m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid
  );
endinterface

// File: rtl/fractal_stream_receiver.sv
// Frame-checking sink for the fractal pixel stream: FIFO buffering, colour mapping, AXI4-Stream out.
// Optional macro FRACTAL_RX_PALETTE_RAM_EN replaces the fixed colour formula with a 256x24 palette RAM.
module fractal_stream_receiver #(
  parameter int FIFO_DEPTH = 1024,
  parameter int MAX_ITER   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] width,
  input  logic [15:0] height,
  fractal_stream_receiver_if.slave bus,
  output logic        overflow,
  output logic        frame_error,
  output logic [15:0] frame_count,
  output logic        synced
`ifdef FRACTAL_RX_PALETTE_RAM_EN
  ,
  input  logic        pal_we,
  input  logic [7:0]  pal_addr,
  input  logic [23:0] pal_wdata
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {WAIT_SOF, RECV} state_e;

  state_e      state_q, state_d;
  logic [15:0] width_q, height_q;
  logic [15:0] in_x_q, in_x_d, in_y_q, in_y_d;
  logic [15:0] pos_x, pos_y, last_x, last_y;
  logic        overflow_q, overflow_d;
  logic        frame_error_q, frame_error_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        exp_sof, exp_le, take, clean;

  logic [9:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        fifo_full, fifo_empty, fifo_wr, fifo_rd;
  logic [9:0]  fifo_wdata, fifo_head;

  logic [23:0] rgb;
  logic [23:0] tdata_q;
  logic        tuser_q, tlast_q, tvalid_q;

  assign last_x  = width_q - 16'd1;
  assign last_y  = height_q - 16'd1;
  assign exp_sof = (in_x_q == 16'd0) && (in_y_q == 16'd0);
  assign exp_le  = (in_x_q == last_x);

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_wdata = {bus.s_frame_start, bus.s_line_end, bus.s_data};
  assign fifo_head  = fifo_mem[rd_ptr_q[AW-1:0]];

  // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    state_d       = state_q;
    in_x_d        = in_x_q;
    in_y_d        = in_y_q;
    overflow_d    = overflow_q;
    frame_error_d = frame_error_q;
    frame_count_d = frame_count_q;
    pos_x         = in_x_q;
    pos_y         = in_y_q;
    take          = 1'b0;
    clean         = 1'b0;
    fifo_wr       = 1'b0;

    if (bus.s_valid) begin
      case (state_q)
        WAIT_SOF: begin
          if (bus.s_frame_start) begin
            if (fifo_full) begin
              overflow_d = 1'b1;
            end else begin
              take    = 1'b1;
              clean   = 1'b1;
              pos_x   = 16'd0;
              pos_y   = 16'd0;
              state_d = RECV;
            end
          end
        end
        RECV: begin
          if (fifo_full) begin
            overflow_d = 1'b1;
            state_d    = WAIT_SOF;
          end else if (bus.s_frame_start && !exp_sof) begin
            // Early frame start: resynchronise on this beat as pixel (0,0).
            frame_error_d = 1'b1;
            take          = 1'b1;
            pos_x         = 16'd0;
            pos_y         = 16'd0;
          end else if ((bus.s_frame_start != exp_sof) || (bus.s_line_end != exp_le)) begin
            frame_error_d = 1'b1;
            state_d       = WAIT_SOF;
          end else begin
            take  = 1'b1;
            clean = 1'b1;
          end
        end
      endcase
    end

    if (take) begin
      fifo_wr = 1'b1;
      if (pos_x == last_x) begin
        in_x_d = 16'd0;
        in_y_d = (pos_y == last_y) ? 16'd0 : pos_y + 16'd1;
        if (clean && (pos_y == last_y)) frame_count_d = frame_count_q + 16'd1;
      end else begin
        in_x_d = pos_x + 16'd1;
        in_y_d = pos_y;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= WAIT_SOF;
      width_q       <= width;
      height_q      <= height;
      in_x_q        <= '0;
      in_y_q        <= '0;
      overflow_q    <= 1'b0;
      frame_error_q <= 1'b0;
      frame_count_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      in_x_q        <= in_x_d;
      in_y_q        <= in_y_d;
      overflow_q    <= overflow_d;
      frame_error_q <= frame_error_d;
      frame_count_q <= frame_count_d;
      wr_ptr_q      <= wr_ptr_q + (AW+1)'(fifo_wr);
      rd_ptr_q      <= rd_ptr_q + (AW+1)'(fifo_rd);
    end
  end

  // NOTE: storage arrays are not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr_q[AW-1:0]] <= fifo_wdata;
  end

`ifdef FRACTAL_RX_PALETTE_RAM_EN
  logic [23:0] pal_mem [256];

  always_ff @(posedge clk) begin
    if (pal_we) pal_mem[pal_addr] <= pal_wdata;
  end

  // Asynchronous read keeps latency unchanged; a same-cycle write is seen only next cycle.
  assign rgb = pal_mem[fifo_head[7:0]];
`else
  assign rgb = (fifo_head[7:0] == 8'(MAX_ITER)) ? 24'h000000
             : {fifo_head[7:0], fifo_head[6:0], 1'b0, 8'hFF - fifo_head[7:0]};
`endif

  // Output register pops the FIFO whenever it is empty or being consumed this cycle.
  assign fifo_rd = (!tvalid_q || bus.m_axis_tready) && !fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
    end else if (fifo_rd) begin
      tvalid_q <= 1'b1;
      tdata_q  <= rgb;
      tuser_q  <= fifo_head[9];
      tlast_q  <= fifo_head[8];
    end else if (bus.m_axis_tready) begin
      tvalid_q <= 1'b0;
    end
  end

  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tuser  = tuser_q;
  assign bus.m_axis_tlast  = tlast_q;

  assign overflow    = overflow_q;
  assign frame_error = frame_error_q;
  assign frame_count = frame_count_q;
  assign synced      = (state_q == RECV);

endmodule

// File: tb/tb_fractal_stream_receiver.sv
// Directed bench for fractal_stream_receiver (4x2 frames, 4-entry FIFO) with an output scoreboard.
module tb_fractal_stream_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] width, height;
  logic        overflow, frame_error, synced;
  logic [15:0] frame_count;

  int tests = 0;
  int fails = 0;
  bit toggle = 1'b0;
  logic [25:0] q[$];
  logic [7:0]  f2 [8];

  fractal_stream_receiver_if intf();

  fractal_stream_receiver #(.FIFO_DEPTH(4), .MAX_ITER(255)) dut (
    .clk         (clk),
    .reset       (reset),
    .width       (width),
    .height      (height),
    .bus         (intf),
    .overflow    (overflow),
    .frame_error (frame_error),
    .frame_count (frame_count),
    .synced      (synced)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] exp_rgb(input logic [7:0] d);
    if (d == 8'd255) return 24'h000000;
    return {d, 8'(d * 2), 8'(255 - d)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (toggle) intf.m_axis_tready = ~intf.m_axis_tready;
    end
  endtask

  task automatic beat(input logic [7:0] d, input logic sof, input logic le, input logic accept);
    intf.s_data        = d;
    intf.s_frame_start = sof;
    intf.s_line_end    = le;
    intf.s_valid       = 1'b1;
    if (accept) q.push_back({sof, le, exp_rgb(d)});
    @(posedge clk); #1;
    intf.s_valid = 1'b0;
    if (toggle) intf.m_axis_tready = ~intf.m_axis_tready;
  endtask

  task automatic send_frame(input logic [7:0] base, input int gap);
    for (int i = 0; i < 8; i++) begin
      beat(base + 8'(i), i == 0, (i % 4) == 3, 1'b1);
      idle(gap);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      idle(1);
      n++;
    end
    check("drain_remaining", q.size(), 0);
  endtask

  // Every visible beat must match the scoreboard head; it only advances on a handshake,
  // so a stalled beat that changes is caught as well.
  always @(negedge clk) begin
    if (!reset && intf.m_axis_tvalid) begin
      check("out_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        check("out_beat", {intf.m_axis_tuser, intf.m_axis_tlast, intf.m_axis_tdata}, q[0]);
        if (intf.m_axis_tready) void'(q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1;
    width = 16'd4;
    height = 16'd2;
    intf.s_data = '0;
    intf.s_frame_start = 1'b0;
    intf.s_line_end = 1'b0;
    intf.s_valid = 1'b0;
    intf.m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", intf.m_axis_tvalid, 0);
    check("rst_tdata", intf.m_axis_tdata, 0);
    check("rst_status", {overflow, frame_error, synced}, 0);
    check("rst_frame_count", frame_count, 0);
    reset = 1'b0;
    width = 16'd9;   // must be ignored: dimensions were captured during reset
    height = 16'd5;

    // Clean frame, with first-beat latency measured.
    beat(8'd0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("lat_n1_tvalid", intf.m_axis_tvalid, 0);
    @(posedge clk); #1;
    check("lat_n2_tvalid", intf.m_axis_tvalid, 1);
    check("lat_n2_tdata", intf.m_axis_tdata, 24'h0000FF);
    check("lat_n2_tuser", intf.m_axis_tuser, 1);
    for (int i = 1; i < 8; i++) beat(8'(i), 1'b0, (i % 4) == 3, 1'b1);
    wait_drain(50);
    check("f1_frame_count", frame_count, 1);
    check("f1_synced", synced, 1);
    check("f1_errors", {overflow, frame_error}, 0);

    // Colour map corners, including the MAX_ITER black override.
    f2 = '{8'd255, 8'd10, 8'd128, 8'd254, 8'd1, 8'd2, 8'd3, 8'd4};
    for (int i = 0; i < 8; i++) beat(f2[i], i == 0, (i % 4) == 3, 1'b1);
    wait_drain(50);
    check("f2_frame_count", frame_count, 2);

    // Overflow: output register holds one beat, FIFO four more; the sixth is dropped.
    intf.m_axis_tready = 1'b0;
    beat(8'd20, 1'b1, 1'b0, 1'b1);
    beat(8'd21, 1'b0, 1'b0, 1'b1);
    beat(8'd22, 1'b0, 1'b0, 1'b1);
    beat(8'd23, 1'b0, 1'b1, 1'b1);
    beat(8'd24, 1'b0, 1'b0, 1'b1);
    beat(8'd25, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("ovf_overflow", overflow, 1);
    check("ovf_synced", synced, 0);
    check("ovf_stall_tvalid", intf.m_axis_tvalid, 1);
    intf.m_axis_tready = 1'b1;
    wait_drain(50);
    check("ovf_sticky", overflow, 1);

    // Beats without frame start are discarded until one arrives.
    beat(8'd30, 1'b0, 1'b0, 1'b0);
    beat(8'd31, 1'b0, 1'b1, 1'b0);
    beat(8'd32, 1'b0, 1'b0, 1'b0);
    send_frame(8'd40, 0);
    wait_drain(50);
    check("nosof_frame_error", frame_error, 0);
    check("nosof_frame_count", frame_count, 3);

    // Early frame start resynchronises in place and the frame completes from there.
    beat(8'd90, 1'b1, 1'b0, 1'b1);
    beat(8'd91, 1'b0, 1'b0, 1'b1);
    beat(8'd92, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i < 8; i++) beat(8'(92 + i), 1'b0, (i % 4) == 3, 1'b1);
    wait_drain(50);
    check("resync_frame_error", frame_error, 1);
    check("resync_frame_count", frame_count, 4);
    check("resync_synced", synced, 1);

    // Missing line end at x=3 drops the beat and waits for the next frame.
    beat(8'd50, 1'b1, 1'b0, 1'b1);
    beat(8'd51, 1'b0, 1'b0, 1'b1);
    beat(8'd52, 1'b0, 1'b0, 1'b1);
    beat(8'd53, 1'b0, 1'b0, 1'b0);
    beat(8'd54, 1'b0, 1'b1, 1'b0);
    idle(1);
    check("le_synced", synced, 0);
    check("le_frame_count", frame_count, 4);
    send_frame(8'd60, 0);
    wait_drain(50);
    check("le_next_frame_count", frame_count, 5);
    check("le_next_synced", synced, 1);

    // tready toggling every cycle over two frames.
    toggle = 1'b1;
    send_frame(8'd100, 1);
    send_frame(8'd150, 1);
    wait_drain(100);
    toggle = 1'b0;
    intf.m_axis_tready = 1'b1;
    idle(1);
    check("tog_frame_count", frame_count, 7);

    // Reset mid-frame while a beat is stalled at the output.
    width = 16'd4;
    height = 16'd2;
    intf.m_axis_tready = 1'b0;
    beat(8'd70, 1'b1, 1'b0, 1'b1);
    beat(8'd71, 1'b0, 1'b0, 1'b1);
    beat(8'd72, 1'b0, 1'b0, 1'b1);
    idle(1);
    check("prerst_tvalid", intf.m_axis_tvalid, 1);
    reset = 1'b1;
    q.delete();
    @(posedge clk); #1;
    check("midrst_tvalid", intf.m_axis_tvalid, 0);
    check("midrst_status", {overflow, frame_error, synced}, 0);
    check("midrst_frame_count", frame_count, 0);
    reset = 1'b0;
    intf.m_axis_tready = 1'b1;
    send_frame(8'd80, 0);
    wait_drain(50);
    check("postrst_frame_count", frame_count, 1);
    check("postrst_status", {overflow, frame_error, synced}, 3'b001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
